pipe_hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage core.
- Generates enable/clear controls for the IF/ID and ID/EX pipeline registers and the PC, covering boot hold-off, load-use stalls, taken-branch flushes, and multi-cycle mul/div waits.
- Sits beside the decode stage; its outputs drive the PC register, the IF/ID register's clear (NOP-insert 0x00000013) and enable, and the ID/EX register's clear and enable.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional HAZARD_PERF_CNT_EN build adds stall/flush counters.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/EX status in, pipeline register controls out.
// The controller takes the slave modport; the pipeline side takes the master modport.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  import hazard_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             md_start;
  logic             md_done;
  logic             pc_en;
  logic             if_id_en;
  logic             if_reg_clr;
  logic             id_ex_en;
  logic             id_ex_clr;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, md_start, md_done,
    input  pc_en, if_id_en, if_reg_clr, id_ex_en, id_ex_clr, md_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, md_start, md_done,
    output pc_en, if_id_en, if_reg_clr, id_ex_en, id_ex_clr, md_timeout,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_detect.sv
// Combinational load-use comparator between the decode sources and the EX load destination.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  // x0 is hardwired to zero, so a load into it can never be a real dependency
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: boot hold-off, load-use stalls, branch flushes, mul/div waits.
// Defining HAZARD_PERF_CNT_EN adds saturating stall/flush counters; otherwise they read 0.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MD_TIMEOUT  = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [BOOT_W-1:0] boot_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              md_timeout_q;
  logic              timeout_set;
  logic              flush_evt;
  logic              load_use;
  logic              pc_en, if_id_en, if_reg_clr, id_ex_en, id_ex_clr;

  hazard_detect u_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      wait_cnt     <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= (state == BOOT) ? boot_cnt + BOOT_W'(1) : '0;
      // Cleared outside MD_WAIT so every wait starts counting from zero
      wait_cnt <= (state == MD_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      if (timeout_set)
        md_timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_reg_clr  = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_clr   = 1'b0;
    timeout_set = 1'b0;
    flush_evt   = 1'b0;
    case (state)
      BOOT: begin
        pc_en      = 1'b0;
        if_reg_clr = 1'b1;
        id_ex_clr  = 1'b1;
        if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1))
          state_nxt = RUN;
      end
      RUN: begin
        // A taken branch squashes decode, so it overrides both mul/div issue and load-use
        if (bus.ex_branch_taken) begin
          if_reg_clr = 1'b1;
          id_ex_clr  = 1'b1;
          flush_evt  = 1'b1;
        end else if (bus.md_start) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          state_nxt = MD_WAIT;
        end else if (load_use) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_clr = 1'b1;
        end
      end
      MD_WAIT: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        if (bus.md_done) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_W'(MD_TIMEOUT - 1)) begin
          state_nxt   = RUN;
          timeout_set = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign bus.pc_en      = pc_en;
  assign bus.if_id_en   = if_id_en;
  assign bus.if_reg_clr = if_reg_clr;
  assign bus.id_ex_en   = id_ex_en;
  assign bus.id_ex_clr  = id_ex_clr;
  assign bus.md_timeout = md_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_evt;

  assign stall_evt = ((state == RUN) || (state == MD_WAIT)) && !pc_en;

  // Both counters saturate rather than wrap so a long run never reads as small
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
